// File: rtl/ct_ifu_icache_data_array_pbank.sv
// Parametrised IFU icache data array with a zeroing init/invalidate sweep.
// Bank 0 owns the MSB slice of din/dout/bwen_b and the MSB of cen_b/par_err.
module ct_ifu_icache_data_array_pbank #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 32,
    parameter int INDEX_W   = 10,
    parameter int INDEX_LSB = 3,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst,
    input  logic [15:0]                   ifu_icache_index,
    input  logic [NUM_BANKS-1:0]          ifu_icache_data_cen_b,
    input  logic                          ifu_icache_data_wen_b,
    input  logic [NUM_BANKS*BANK_W-1:0]   ifu_icache_data_bwen_b,
    input  logic [NUM_BANKS*BANK_W-1:0]   ifu_icache_data_din,
    input  logic                          ifu_icache_data_par_flip,
    input  logic                          ifu_icache_data_inv_req,
    output logic [NUM_BANKS*BANK_W-1:0]   icache_ifu_data_dout,
    output logic [NUM_BANKS-1:0]          icache_ifu_data_par_err,
    output logic                          icache_ifu_data_init_busy
);

    localparam int DEPTH = 1 << INDEX_W;

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic               state;
    logic [INDEX_W-1:0] cnt;
    logic [INDEX_W-1:0] addr;
    logic               ready;
    logic               unused_in;

    assign addr  = ifu_icache_index[INDEX_LSB +: INDEX_W];
    assign ready = (state == ST_READY);
    assign icache_ifu_data_init_busy = (state == ST_INIT);
    assign unused_in = ^{ifu_icache_index, ifu_icache_data_par_flip};

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {INDEX_W{1'b1}}) begin
                        state <= ST_READY;
                    end
                end
                default: begin
                    if (ifu_icache_data_inv_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam int SL = (NUM_BANKS - 1 - b) * BANK_W;
        localparam int PB = NUM_BANKS - 1 - b;

        logic [BANK_W-1:0] mem [DEPTH];
        logic [BANK_W-1:0] din_s;
        logic [BANK_W-1:0] bwen_s;
        logic [BANK_W-1:0] rd_word;
        logic [BANK_W-1:0] wr_word;
        logic [BANK_W-1:0] dout_q;
        logic              rd_par;
        logic              perr_q;
        logic              acc_rd;
        logic              acc_wr;

        assign din_s   = ifu_icache_data_din[SL +: BANK_W];
        assign bwen_s  = ifu_icache_data_bwen_b[SL +: BANK_W];
        assign rd_word = mem[addr];
        assign wr_word = (din_s & ~bwen_s) | (rd_word & bwen_s);
        assign acc_rd  = ready & ~ifu_icache_data_cen_b[PB] & ifu_icache_data_wen_b;
        assign acc_wr  = ready & ~ifu_icache_data_cen_b[PB] & ~ifu_icache_data_wen_b;

        always_ff @(posedge forever_cpuclk) begin
            if (!ready) begin
                mem[cnt] <= '0;
            end else if (acc_wr) begin
                mem[addr] <= wr_word;
            end
        end

        if (PARITY_EN) begin : g_par
            logic par_mem [DEPTH];

            always_ff @(posedge forever_cpuclk) begin
                if (!ready) begin
                    par_mem[cnt] <= 1'b0;
                end else if (acc_wr) begin
                    par_mem[addr] <= (^wr_word) ^ ifu_icache_data_par_flip;
                end
            end

            assign rd_par = par_mem[addr];
        end else begin : g_nopar
            assign rd_par = 1'b0;
        end

        // Writes and INIT cycles leave the read registers untouched.
        always_ff @(posedge forever_cpuclk) begin
            if (cpurst) begin
                dout_q <= '0;
                perr_q <= 1'b0;
            end else if (ready) begin
                if (acc_rd) begin
                    dout_q <= rd_word;
                    perr_q <= PARITY_EN & (^{rd_word, rd_par});
                end else if (ifu_icache_data_cen_b[PB]) begin
                    perr_q <= 1'b0;
                end
            end
        end

        assign icache_ifu_data_dout[SL +: BANK_W] = dout_q;
        assign icache_ifu_data_par_err[PB]        = perr_q;
    end

endmodule

// File: tb/tb_ct_ifu_icache_data_array_pbank.sv
// Scoreboard bench for ct_ifu_icache_data_array_pbank.
module tb_ct_ifu_icache_data_array_pbank;

    logic         clk = 1'b0;
    logic         cpurst;
    logic [15:0]  index;
    logic [3:0]   cen_b;
    logic         wen_b;
    logic [127:0] bwen_b;
    logic [127:0] din;
    logic         par_flip;
    logic         inv_req;
    logic [127:0] dout;
    logic [3:0]   par_err;
    logic         busy;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   p;
        logic         b;
        bit           cd;
        bit           cp;
        bit           cb;
        string        name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [127:0] W0 =
        128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] W1 =
        128'h1111BEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] W2 =
        128'h1111BEEF_01234567_13572468_CAFEF00D;

    always #5 clk = ~clk;

    ct_ifu_icache_data_array_pbank dut (
        .forever_cpuclk            (clk),
        .cpurst                    (cpurst),
        .ifu_icache_index          (index),
        .ifu_icache_data_cen_b     (cen_b),
        .ifu_icache_data_wen_b     (wen_b),
        .ifu_icache_data_bwen_b    (bwen_b),
        .ifu_icache_data_din       (din),
        .ifu_icache_data_par_flip  (par_flip),
        .ifu_icache_data_inv_req   (inv_req),
        .icache_ifu_data_dout      (dout),
        .icache_ifu_data_par_err   (par_err),
        .icache_ifu_data_init_busy (busy)
    );

    task automatic idle_in();
        index    = '0;
        cen_b    = 4'hF;
        wen_b    = 1'b1;
        bwen_b   = '1;
        din      = '0;
        par_flip = 1'b0;
        inv_req  = 1'b0;
    endtask

    // Inputs are already driven; the expectation applies after this edge.
    task automatic step(input logic [127:0] ed, input logic [3:0] ep,
                        input logic eb, input bit cd, input bit cp,
                        input bit cb, input string nm);
        exp_t e;
        @(posedge clk);
        e.d = ed; e.p = ep; e.b = eb;
        e.cd = cd; e.cp = cp; e.cb = cb; e.name = nm;
        q.push_back(e);
        #1;
        idle_in();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.cd) begin
                    n_vec++;
                    if (dout !== e.d) begin
                        n_err++;
                        $display("FAIL %s dout got=%h want=%h", e.name, dout, e.d);
                    end
                end
                if (e.cp) begin
                    n_vec++;
                    if (par_err !== e.p) begin
                        n_err++;
                        $display("FAIL %s par_err got=%b want=%b", e.name, par_err, e.p);
                    end
                end
                if (e.cb) begin
                    n_vec++;
                    if (busy !== e.b) begin
                        n_err++;
                        $display("FAIL %s init_busy got=%b want=%b", e.name, busy, e.b);
                    end
                end
            end
        end
    end

    task automatic sweep(input logic [127:0] hold_d, input string nm);
        for (int k = 0; k < 1024; k++) begin
            step(hold_d, 4'b0, (k < 1023), 1'b0, 1'b0, 1'b1, nm);
        end
    endtask

    task automatic rd(input logic [15:0] idx);
        index = idx;
        cen_b = 4'h0;
        wen_b = 1'b1;
    endtask

    task automatic wr(input logic [15:0] idx, input logic [3:0] cen,
                      input logic [127:0] bw, input logic [127:0] d,
                      input logic flip);
        index    = idx;
        cen_b    = cen;
        wen_b    = 1'b0;
        bwen_b   = bw;
        din      = d;
        par_flip = flip;
    endtask

    initial begin
        idle_in();
        cpurst = 1'b1;
        @(posedge clk);
        #1;
        step(128'h0, 4'b0, 1'b1, 1'b1, 1'b1, 1'b1, "reset");
        cpurst = 1'b0;
        sweep(128'h0, "init_sweep");

        for (int a = 0; a < 1024; a++) begin
            rd(16'(a << 3));
            step(128'h0, 4'b0, 1'b0, 1'b1, 1'b1, (a == 0), "zero_read");
        end

        wr(16'h0018, 4'h0, 128'h0, W0, 1'b0);
        step(128'h0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "full_write_hold");
        rd(16'h0018);
        step(W0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "full_read");

        wr(16'h0018, 4'h0, {16'h0000, {112{1'b1}}},
           {32'h1111_2222, 96'h0}, 1'b0);
        step(W0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mask_write_hold");
        rd(16'h0018);
        step(W1, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mask_read");

        wr(16'h0018, 4'b1101, 128'h0, {64'h0, 32'h1357_2468, 32'h0}, 1'b1);
        step(W1, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "flip_write_hold");
        rd(16'h0018);
        step(W2, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, "parity_err");
        step(W2, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, "parity_pulse_end");

        inv_req = 1'b1;
        step(W2, 4'b0, 1'b1, 1'b1, 1'b1, 1'b1, "inv_start");
        for (int k = 0; k < 1024; k++) begin
            if (k == 5) begin
                rd(16'h0018);
                step(W2, 4'b0, 1'b1, 1'b1, 1'b1, 1'b1, "read_in_sweep");
            end else begin
                step(W2, 4'b0, (k < 1023), 1'b0, 1'b0, 1'b1, "inv_sweep");
            end
        end
        rd(16'h0018);
        step(128'h0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "post_inv_read");

        wr(16'h0018, 4'h0, 128'h0, W0, 1'b0);
        step(128'h0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rewrite");
        rd(16'h0018);
        step(W0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0, "reread");
        inv_req = 1'b1;
        step(W0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, "inv2_start");
        for (int k = 0; k < 500; k++) begin
            step(W0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, "inv2_sweep");
        end
        cpurst = 1'b1;
        step(128'h0, 4'b0, 1'b1, 1'b1, 1'b1, 1'b1, "mid_sweep_reset");
        cpurst = 1'b0;
        sweep(128'h0, "restart_sweep");
        rd(16'h0018);
        step(128'h0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b1, "final_read");

        repeat (3) @(posedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
